// File: rtl/id_operand_stage_if.sv
// Signal bundle of the decode/operand stage: fetch handshake, regfile read port,
// forwarding network, execute handshake, branch redirect and stall statistics.
interface id_operand_stage_if #(
    parameter int DATA_W  = 32,
    parameter int NUM_FWD = 3,
    parameter int CNT_W   = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [31:0]               in_pc;
    logic [31:0]               in_inst;
    logic [4:0]                rf_raddr1;
    logic [4:0]                rf_raddr2;
    logic [DATA_W-1:0]         rf_rdata1;
    logic [DATA_W-1:0]         rf_rdata2;
    logic [NUM_FWD-1:0]        fwd_we;
    logic [NUM_FWD-1:0]        fwd_pend;
    logic [5*NUM_FWD-1:0]      fwd_waddr;
    logic [DATA_W*NUM_FWD-1:0] fwd_wdata;
    logic                      out_valid;
    logic                      out_ready;
    logic [31:0]               out_pc;
    logic [31:0]               out_inst;
    logic [DATA_W-1:0]         out_src1;
    logic [DATA_W-1:0]         out_src2;
    logic                      br_e;
    logic [31:0]               br_addr;
    logic [CNT_W-1:0]          stall_cnt;

    modport slave (
        input  in_valid, in_pc, in_inst, rf_rdata1, rf_rdata2,
               fwd_we, fwd_pend, fwd_waddr, fwd_wdata, out_ready,
        output in_ready, rf_raddr1, rf_raddr2, out_valid, out_pc, out_inst,
               out_src1, out_src2, br_e, br_addr, stall_cnt
    );

    modport master (
        output in_valid, in_pc, in_inst, rf_rdata1, rf_rdata2,
               fwd_we, fwd_pend, fwd_waddr, fwd_wdata, out_ready,
        input  in_ready, rf_raddr1, rf_raddr2, out_valid, out_pc, out_inst,
               out_src1, out_src2, br_e, br_addr, stall_cnt
    );
endinterface

// File: rtl/id_operand_stage.sv
// Decode/operand stage: holds one fetched instruction, resolves rs/rt through the
// forwarding network, stalls on in-flight loads and issues branch redirects.
module id_operand_stage #(
    parameter int DATA_W  = 32,
    parameter int NUM_FWD = 3,
    parameter int CNT_W   = 16
) (
    input logic               clk,
    input logic               resetn,
    input logic               flush,
    id_operand_stage_if.slave bus
);
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] FN_JR      = 6'b001000;

    typedef struct packed {
        logic              pend;
        logic [DATA_W-1:0] data;
    } operand_t;

    // Lowest matching index wins, so scan from oldest to youngest and let later hits override.
    function automatic operand_t resolve(
        input logic [4:0]                addr,
        input logic [DATA_W-1:0]         rf_data,
        input logic [NUM_FWD-1:0]        we,
        input logic [NUM_FWD-1:0]        pend,
        input logic [5*NUM_FWD-1:0]      waddr,
        input logic [DATA_W*NUM_FWD-1:0] wdata
    );
        operand_t r;
        r.pend = 1'b0;
        r.data = rf_data;
        if (addr == 5'd0) begin
            r.data = '0;
        end else begin
            for (int i = NUM_FWD - 1; i >= 0; i--) begin
                if (we[i] && (waddr[5*i +: 5] == addr)) begin
                    r.pend = pend[i];
                    r.data = wdata[DATA_W*i +: DATA_W];
                end
            end
        end
        return r;
    endfunction

    logic              r_h_valid;
    logic [31:0]       r_h_pc;
    logic [31:0]       r_h_inst;
    logic              r_o_valid;
    logic [31:0]       r_o_pc;
    logic [31:0]       r_o_inst;
    logic [DATA_W-1:0] r_o_src1;
    logic [DATA_W-1:0] r_o_src2;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic [5:0]        w_op;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [5:0]        w_func;
    logic [15:0]       w_imm;
    logic [25:0]       w_index;
    logic              w_use_rs;
    logic              w_use_rt;
    operand_t          w_res1;
    operand_t          w_res2;
    logic              w_hazard;
    logic              w_move;
    logic              w_accept;
    logic [31:0]       w_pc4;
    logic [31:0]       w_br_tgt;
    logic              w_taken;
    logic [31:0]       w_br_addr;
    logic [DATA_W-1:0] w_src1_next;
    logic [DATA_W-1:0] w_src2_next;

    assign w_op    = r_h_inst[31:26];
    assign w_rs    = r_h_inst[25:21];
    assign w_rt    = r_h_inst[20:16];
    assign w_func  = r_h_inst[5:0];
    assign w_imm   = r_h_inst[15:0];
    assign w_index = r_h_inst[25:0];

    assign w_use_rs = !((w_op == OP_J) || (w_op == OP_JAL) || (w_op == OP_LUI));
    assign w_use_rt = (w_op == OP_SPECIAL) || (w_op == OP_BEQ) || (w_op == OP_BNE) || (w_op == OP_SW);

    assign w_res1 = resolve(w_rs, bus.rf_rdata1, bus.fwd_we, bus.fwd_pend, bus.fwd_waddr, bus.fwd_wdata);
    assign w_res2 = resolve(w_rt, bus.rf_rdata2, bus.fwd_we, bus.fwd_pend, bus.fwd_waddr, bus.fwd_wdata);

    assign w_hazard = r_h_valid && ((w_use_rs && w_res1.pend) || (w_use_rt && w_res2.pend));
    assign w_move   = r_h_valid && !w_hazard && (!r_o_valid || bus.out_ready);
    assign w_accept = bus.in_valid && bus.in_ready;

    assign w_pc4    = r_h_pc + 32'd4;
    assign w_br_tgt = w_pc4 + {{14{w_imm[15]}}, w_imm, 2'b00};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_taken   = 1'b0;
        w_br_addr = '0;
        case (w_op)
            OP_BEQ: begin
                w_taken   = (w_res1.data == w_res2.data);
                w_br_addr = w_br_tgt;
            end
            OP_BNE: begin
                w_taken   = (w_res1.data != w_res2.data);
                w_br_addr = w_br_tgt;
            end
            OP_J, OP_JAL: begin
                w_taken   = 1'b1;
                w_br_addr = {w_pc4[31:28], w_index, 2'b00};
            end
            OP_SPECIAL: begin
                if (w_func == FN_JR) begin
                    w_taken   = 1'b1;
                    w_br_addr = 32'(w_res1.data);
                end
            end
            default: ;
        endcase
    end

    // jal hands the link address to execute in place of its operands.
    assign w_src1_next = (w_op == OP_JAL) ? DATA_W'(r_h_pc + 32'd8) : w_res1.data;
    assign w_src2_next = (w_op == OP_JAL) ? '0 : w_res2.data;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: payload registers are reset too so a discarded instruction leaves no stale pc/operands.
            r_h_valid   <= 1'b0;
            r_h_pc      <= '0;
            r_h_inst    <= '0;
            r_o_valid   <= 1'b0;
            r_o_pc      <= '0;
            r_o_inst    <= '0;
            r_o_src1    <= '0;
            r_o_src2    <= '0;
            r_stall_cnt <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            if (w_hazard && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (flush) begin
                r_h_valid <= 1'b0;
                r_o_valid <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_h_valid <= 1'b1;
                    r_h_pc    <= bus.in_pc;
                    r_h_inst  <= bus.in_inst;
                end else if (w_move) begin
                    r_h_valid <= 1'b0;
                end
                if (w_move) begin
                    r_o_valid <= 1'b1;
                    r_o_pc    <= r_h_pc;
                    r_o_inst  <= r_h_inst;
                    r_o_src1  <= w_src1_next;
                    r_o_src2  <= w_src2_next;
                end else if (bus.out_ready) begin
                    r_o_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = !r_h_valid || w_move;
    assign bus.rf_raddr1 = w_rs;
    assign bus.rf_raddr2 = w_rt;
    assign bus.out_valid = r_o_valid;
    assign bus.out_pc    = r_o_pc;
    assign bus.out_inst  = r_o_inst;
    assign bus.out_src1  = r_o_src1;
    assign bus.out_src2  = r_o_src2;
    assign bus.br_e      = w_move && !flush && w_taken;
    assign bus.br_addr   = w_br_addr;
    assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: inputs change on the falling edge and
// outputs are sampled 1 time unit later, well away from the rising edge.
module tb_id_operand_stage;
    localparam int DATA_W  = 32;
    localparam int NUM_FWD = 3;
    localparam int CNT_W   = 3;

    logic clk = 1'b0;
    logic resetn;
    logic flush;
    int   total = 0;
    int   bad   = 0;

    logic [NUM_FWD-1:0]        fwd_we;
    logic [NUM_FWD-1:0]        fwd_pend;
    logic [5*NUM_FWD-1:0]      fwd_waddr;
    logic [DATA_W*NUM_FWD-1:0] fwd_wdata;

    id_operand_stage_if #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) bus ();

    id_operand_stage #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Register file model: register n reads as 0xA000_0000 + n.
    assign bus.rf_rdata1 = 32'hA000_0000 | {27'd0, bus.rf_raddr1};
    assign bus.rf_rdata2 = 32'hA000_0000 | {27'd0, bus.rf_raddr2};
    assign bus.fwd_we    = fwd_we;
    assign bus.fwd_pend  = fwd_pend;
    assign bus.fwd_waddr = fwd_waddr;
    assign bus.fwd_wdata = fwd_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_type(input logic [5:0] op, input logic [25:0] idx);
        return {op, idx};
    endfunction

    task automatic set_fwd(input int i, input logic we, input logic pend,
                           input logic [4:0] addr, input logic [31:0] data);
        fwd_we[i]               = we;
        fwd_pend[i]             = pend;
        fwd_waddr[5*i +: 5]     = addr;
        fwd_wdata[DATA_W*i +: DATA_W] = data;
    endtask

    task automatic clear_fwd();
        fwd_we    = '0;
        fwd_pend  = '0;
        fwd_waddr = '0;
        fwd_wdata = '0;
    endtask

    // Presents one instruction for a single cycle; pipe must be empty on entry.
    task automatic load_h(input logic [31:0] pc, input logic [31:0] inst);
        bus.in_valid = 1'b1;
        bus.in_pc    = pc;
        bus.in_inst  = inst;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic br_case(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                           input logic exp_e, input logic [31:0] exp_addr);
        load_h(pc, inst);
        #1;
        check({tag, "_br_e"}, bus.br_e, exp_e);
        check({tag, "_br_addr"}, bus.br_addr, exp_addr);
        tick();
        check({tag, "_out_valid"}, bus.out_valid, 1);
        check({tag, "_out_pc"}, bus.out_pc, pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn        = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_inst   = '0;
        bus.out_ready = 1'b1;
        clear_fwd();
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_br_e", bus.br_e, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_stall_cnt", bus.stall_cnt, 0);
        check("rst_out_pc", bus.out_pc, 0);
        check("rst_out_src1", bus.out_src1, 0);
        @(negedge clk);
        resetn = 1'b1;

        // Back-to-back addu stream: out_valid two cycles after accept, then one per cycle.
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                bus.in_valid = 1'b1;
                bus.in_pc    = 32'h100 + 32'(4 * i);
                bus.in_inst  = r_type(5'(i + 1), 5'(i + 2), 5'd10, 6'h21);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            check("stream_in_ready", bus.in_ready, 1);
            check("stream_out_valid", bus.out_valid, (i >= 2) ? 1 : 0);
            if (i >= 2) begin
                check("stream_out_pc", bus.out_pc, 32'h100 + 32'(4 * (i - 2)));
                check("stream_src1", bus.out_src1, 32'hA000_0000 + 32'(i - 1));
                check("stream_src2", bus.out_src2, 32'hA000_0000 + 32'(i));
            end
            tick();
        end
        check("stream_stall_cnt", bus.stall_cnt, 0);

        // Youngest forwarding source wins.
        load_h(32'h200, r_type(5'd5, 5'd6, 5'd10, 6'h21));
        set_fwd(0, 1'b1, 1'b0, 5'd5, 32'h11);
        set_fwd(2, 1'b1, 1'b0, 5'd5, 32'h22);
        #1;
        check("prio_in_ready", bus.in_ready, 1);
        tick();
        clear_fwd();
        check("prio_src1", bus.out_src1, 32'h11);
        check("prio_src2", bus.out_src2, 32'hA000_0006);

        // Load-use hazard on rt for three cycles.
        load_h(32'h300, r_type(5'd3, 5'd7, 5'd10, 6'h21));
        set_fwd(1, 1'b1, 1'b1, 5'd7, 32'h77);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("haz_in_ready", bus.in_ready, 0);
            check("haz_out_valid", bus.out_valid, 0);
            tick();
        end
        fwd_pend = '0;
        #1;
        check("haz_release_in_ready", bus.in_ready, 1);
        check("haz_stall_cnt", bus.stall_cnt, 3);
        tick();
        clear_fwd();
        check("haz_out_valid_after", bus.out_valid, 1);
        check("haz_src1", bus.out_src1, 32'hA000_0003);
        check("haz_src2", bus.out_src2, 32'h77);

        // Branch and jump redirects.
        br_case("beq_back", 32'h0040_0000, i_type(6'b000100, 5'd4, 5'd4, 16'hFFFF), 1'b1, 32'h0040_0000);
        br_case("beq_nt", 32'h0000_1000, i_type(6'b000100, 5'd1, 5'd2, 16'h0010), 1'b0, 32'h0000_1044);
        br_case("bne_t", 32'h0000_2000, i_type(6'b000101, 5'd1, 5'd2, 16'h0003), 1'b1, 32'h0000_2010);
        br_case("bne_nt", 32'h0000_2000, i_type(6'b000101, 5'd4, 5'd4, 16'h0003), 1'b0, 32'h0000_2010);
        br_case("j", 32'h3000_0000, j_type(6'b000010, 26'h10), 1'b1, 32'h3000_0040);
        br_case("j_wrap", 32'hFFFF_FFFC, j_type(6'b000010, 26'h1), 1'b1, 32'h0000_0004);
        br_case("jal", 32'h3000_0000, j_type(6'b000011, 26'h100), 1'b1, 32'h3000_0400);
        check("jal_src1", bus.out_src1, 32'h3000_0008);
        check("jal_src2", bus.out_src2, 32'h0);
        br_case("jr", 32'h0000_0100, r_type(5'd9, 5'd0, 5'd0, 6'h08), 1'b1, 32'hA000_0009);
        br_case("addu_nobr", 32'h0000_0104, r_type(5'd1, 5'd2, 5'd3, 6'h21), 1'b0, 32'h0);

        // lui ignores a pending write to its rs field.
        set_fwd(0, 1'b1, 1'b1, 5'd5, 32'h55);
        br_case("lui", 32'h0000_0400, i_type(6'b001111, 5'd5, 5'd6, 16'h1234), 1'b0, 32'h0);
        clear_fwd();
        check("lui_stall_cnt", bus.stall_cnt, 3);

        // Backpressure with O and H full; r0 pending write never stalls.
        load_h(32'h500, r_type(5'd1, 5'd2, 5'd3, 6'h21));
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h504;
        bus.in_inst  = r_type(5'd0, 5'd0, 5'd3, 6'h21);
        set_fwd(0, 1'b1, 1'b1, 5'd0, 32'hDEAD);
        #1;
        check("bp_fill_in_ready", bus.in_ready, 1);
        tick();
        bus.out_ready = 1'b0;
        bus.in_pc     = 32'h508;
        bus.in_inst   = r_type(5'd3, 5'd4, 5'd3, 6'h21);
        #1;
        check("bp_in_ready", bus.in_ready, 0);
        tick();
        check("bp_out_valid", bus.out_valid, 1);
        check("bp_out_pc_1", bus.out_pc, 32'h500);
        check("bp_in_ready_hold", bus.in_ready, 0);
        tick();
        check("bp_out_pc_2", bus.out_pc, 32'h500);
        bus.out_ready = 1'b1;
        #1;
        check("bp_r0_in_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_b_pc", bus.out_pc, 32'h504);
        check("bp_r0_src1", bus.out_src1, 32'h0);
        check("bp_r0_src2", bus.out_src2, 32'h0);
        tick();
        check("bp_c_pc", bus.out_pc, 32'h508);
        clear_fwd();
        tick();
        check("bp_stall_cnt", bus.stall_cnt, 3);

        // Long stall saturates the counter; flush then discards the stalled instruction.
        load_h(32'h600, r_type(5'd3, 5'd7, 5'd10, 6'h21));
        set_fwd(1, 1'b1, 1'b1, 5'd7, 32'h77);
        repeat (6) tick();
        check("sat_stall_cnt", bus.stall_cnt, 7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        clear_fwd();
        check("sat_flush_in_ready", bus.in_ready, 1);
        check("sat_flush_out_valid", bus.out_valid, 0);

        // Flush with a taken jr in H, also overriding a same-cycle accept.
        load_h(32'h700, r_type(5'd9, 5'd0, 5'd0, 6'h08));
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h900;
        bus.in_inst  = r_type(5'd1, 5'd2, 5'd3, 6'h21);
        #1;
        check("flush_br_e", bus.br_e, 0);
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_out_valid", bus.out_valid, 0);
        check("flush_in_ready", bus.in_ready, 1);
        tick();
        check("flush_no_accept", bus.out_valid, 0);

        // Asynchronous reset mid-stream with a taken jr about to move.
        load_h(32'hA00, r_type(5'd1, 5'd2, 5'd3, 6'h21));
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'hA04;
        bus.in_inst  = r_type(5'd9, 5'd0, 5'd0, 6'h08);
        tick();
        bus.in_valid = 1'b0;
        #1;
        check("pre_rst_br_e", bus.br_e, 1);
        resetn = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_br_e", bus.br_e, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_stall_cnt", bus.stall_cnt, 0);
        check("mid_rst_out_pc", bus.out_pc, 0);
        check("mid_rst_out_inst", bus.out_inst, 0);
        tick();
        resetn = 1'b1;
        tick();
        check("post_rst_out_valid", bus.out_valid, 0);

        // First edge after reset release accepts.
        load_h(32'hB00, r_type(5'd1, 5'd2, 5'd3, 6'h21));
        tick();
        check("post_rst_accept_valid", bus.out_valid, 1);
        check("post_rst_accept_pc", bus.out_pc, 32'hB00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_operand_stage.md
ID_OPERAND_STAGE -- requirements
Module: id_operand_stage

Interface
REQ-001 Parameter DATA_W, default 32, register/operand data width.
REQ-002 Parameter NUM_FWD, default 3, number of forwarding sources; index 0 = youngest (highest priority).
REQ-003 Parameter CNT_W, default 16, width of hazard-stall counter.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous kill of both stage registers.
REQ-007 in_valid / in_ready  input / output  1 / 1  fetch handshake.
REQ-008 in_pc / in_inst  input  32 / 32  fetched PC and instruction.
REQ-009 rf_raddr1 / rf_raddr2  output  5 / 5  regfile read addresses (rs / rt of held instruction).
REQ-010 rf_rdata1 / rf_rdata2  input  DATA_W / DATA_W  combinational regfile read data.
REQ-011 fwd_we / fwd_pend  input  NUM_FWD / NUM_FWD  source writes a register / its data not yet available (load in flight).
REQ-012 fwd_waddr / fwd_wdata  input  5*NUM_FWD / DATA_W*NUM_FWD  packed destination addresses and data, source i at slice i.
REQ-013 out_valid / out_ready  output / input  1 / 1  execute-side handshake.
REQ-014 out_pc, out_inst, out_src1, out_src2  output  32, 32, DATA_W, DATA_W  registered decoded operands.
REQ-015 br_e / br_addr  output  1 / 32  redirect request and target, combinational, valid in the transfer cycle only.
REQ-016 stall_cnt  output  CNT_W  saturating count of hazard-stall cycles.

Function
REQ-017 Two registers SHALL exist: hold register H (valid, pc, inst) and output register O (valid, pc, inst, src1, src2).
REQ-018 in_ready SHALL equal ~H.valid | move, where move = H.valid & ~hazard & (~O.valid | out_ready).
REQ-019 H SHALL load in_pc/in_inst when in_valid & in_ready; H.valid SHALL clear on move without a new input.
REQ-020 O SHALL load H contents plus resolved operands on move; O.valid SHALL clear when out_ready & ~move.
REQ-021 Accept-to-out_valid latency SHALL be 2 cycles with no hazard and out_ready high; sustained throughput 1 instruction/cycle.
REQ-022 Operand resolution per source: if address is 0 then 0; else lowest index i with fwd_we[i] & fwd_waddr[i]==addr supplies fwd_wdata[i]; else rf_rdata.
REQ-023 Register 0 SHALL never be forwarded nor cause a hazard.
REQ-024 use_rs SHALL be 1 for all opcodes except j (000010), jal (000011), lui (001111); use_rt SHALL be 1 for opcode 000000, beq (000100), bne (000101), sw (101011).
REQ-025 hazard SHALL be 1 when a used source's winning match (REQ-022) has fwd_pend set.
REQ-026 While hazard, H SHALL hold, no move occurs, stall_cnt increments by 1 per cycle, saturating at all-ones.
REQ-027 br_e SHALL assert only in a move cycle for: beq with src1==src2, bne with src1!=src2, j, jal, jr (op 000000, func 001000).
REQ-028 br_addr: beq/bne = pc+4+sign_ext(imm)<<2; j/jal = {(pc+4)[31:28], index, 2'b00}; jr = resolved src1; else 0.
REQ-029 jal SHALL place pc+8 in out_src1 and 0 in out_src2.
REQ-030 flush SHALL clear H.valid and O.valid next edge, override in-cycle accept and move, and force br_e to 0.
REQ-031 Arithmetic on pc SHALL wrap modulo 2^32.

Reset
REQ-032 On resetn low, immediately: H.valid=0, O.valid=0, all stored pc/inst/operands=0, stall_cnt=0; outputs out_valid=0, br_e=0, in_ready=1.
REQ-033 Reset deassertion SHALL be synchronised by integration; block accepts input on first edge after resetn high.
REQ-034 Reset asserted mid-stall or mid-transfer SHALL discard all in-flight instructions with no br_e pulse.

Verification
REQ-035 Back-to-back addu stream, out_ready=1 -> first out_valid 2 cycles after accept, then one instruction per cycle, no stall.
REQ-036 rs=5, fwd0 and fwd2 both write r5 (0x11, 0x22), no pend -> out_src1=0x11.
REQ-037 rt=7, fwd1 write r7 with fwd_pend=1 for 3 cycles -> in_ready=0, out_valid gap, stall_cnt=3, then out_src2=fwd1 data.
REQ-038 beq pc=0x00400000, imm=0xFFFF, src1==src2 -> br_e=1, br_addr=0x00400000.
REQ-039 out_ready=0 with O and H full -> in_ready=0, O and H contents stable; rs=0 with fwd_we to r0 pending -> no hazard, src=0.
REQ-040 flush asserted with br_e-eligible jr in H -> br_e=0, out_valid=0 next cycle; resetn pulse mid-stream -> all outputs to reset values asynchronously.
